// File: rtl/rd_port_sched.sv
// Per-output-port read scheduler: packet-granular round-robin over input-port
// buffers, drives the read-mux select/enable and pops the granted buffer to eop.
module rd_port_sched #(
    parameter int unsigned IN_PORT_NUM = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [IN_PORT_NUM-1:0]         i_req,
    input  logic                           i_out_rdy,
    input  logic                           i_rd_vld,
    input  logic                           i_rd_sop,
    input  logic                           i_rd_eop,
    output logic [$clog2(IN_PORT_NUM)-1:0] o_sel,
    output logic                           o_en,
    output logic [IN_PORT_NUM-1:0]         o_pop,
    output logic                           o_busy,
    output logic                           o_timeout,
    output logic                           o_err_sop
);

    localparam int unsigned SEL_W = $clog2(IN_PORT_NUM);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt, sel_nxt, win, idx;
    logic             en_nxt, first, first_nxt, found;
    logic [CNT_W-1:0] stall_cnt, stall_nxt;
    logic             xfer, stall, to_hit;

    // Round-robin search: first requester at or above ptr, wrapping.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < IN_PORT_NUM; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && i_req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // A word is never popped during the reset cycle, so an aborted packet stays intact.
    assign xfer   = (state == XFER) & o_en & i_out_rdy & i_rd_vld & i_rst_n;
    assign stall  = (state == XFER) & o_en & i_out_rdy & ~i_rd_vld;
    assign to_hit = stall & (stall_cnt == CNT_W'(TIMEOUT - 1));

    assign o_busy    = (state == XFER);
    assign o_timeout = to_hit;
    assign o_err_sop = xfer & (first ? ~i_rd_sop : i_rd_sop);

    always_comb begin
        o_pop = '0;
        if (xfer) begin
            o_pop[o_sel] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = o_sel;
        en_nxt    = o_en;
        first_nxt = first;
        stall_nxt = stall_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nxt   = win;
                    en_nxt    = 1'b1;
                    first_nxt = 1'b1;
                    stall_nxt = '0;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (xfer) begin
                    first_nxt = 1'b0;
                    stall_nxt = '0;
                    if (i_rd_eop) begin
                        ptr_nxt   = o_sel + SEL_W'(1);
                        en_nxt    = 1'b0;
                        state_nxt = GAP;
                    end
                end else if (to_hit) begin
                    stall_nxt = CNT_W'(TIMEOUT);
                    ptr_nxt   = o_sel + SEL_W'(1);
                    en_nxt    = 1'b0;
                    state_nxt = GAP;
                end else if (stall && (stall_cnt != CNT_W'(TIMEOUT))) begin
                    stall_nxt = stall_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                en_nxt    = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                en_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            o_sel     <= '0;
            o_en      <= 1'b0;
            first     <= 1'b1;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            o_sel     <= sel_nxt;
            o_en      <= en_nxt;
            first     <= first_nxt;
            stall_cnt <= stall_nxt;
        end
    end

endmodule

// File: tb/tb_rd_port_sched.sv
// Scoreboard bench for rd_port_sched: each driven cycle queues its expected
// outputs; a negedge monitor pops and compares, and flags unexpected pulses.
module tb_rd_port_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        rdy, vld, sop, eop;
    logic [3:0]  sel;
    logic        en, busy, tmo, err;
    logic [15:0] pop;

    always #5 clk = ~clk;

    rd_port_sched #(
        .IN_PORT_NUM(16),
        .TIMEOUT    (4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_out_rdy(rdy),
        .i_rd_vld (vld),
        .i_rd_sop (sop),
        .i_rd_eop (eop),
        .o_sel    (sel),
        .o_en     (en),
        .o_pop    (pop),
        .o_busy   (busy),
        .o_timeout(tmo),
        .o_err_sop(err)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [23:0] exp;
    } exp_t;

    exp_t        q[$];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    string       tname = "init";
    logic [23:0] got_v;

    always @(posedge clk) cyc <= cyc + 1;

    // in = {rdy, vld, sop, eop}; te = {timeout, err_sop}
    task automatic drive(input logic [15:0] r, input logic [3:0] in, input logic e,
                         input logic [3:0] s, input logic [15:0] p, input logic [1:0] te);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = r;
        {rdy, vld, sop, eop} = in;
        x.cyc  = cyc;
        x.name = tname;
        x.exp  = {e, e, s, p, te};
        q.push_back(x);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = '0;
        {rdy, vld, sop, eop} = 4'b1100;
    endtask

    always @(negedge clk) begin
        got_v = {en, busy, sel, pop, tmo, err};
        if (q.size() > 0 && q[0].cyc == cyc) begin
            n_cmp++;
            if (got_v !== q[0].exp) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got en=%b busy=%b sel=%0d pop=%h to=%b err=%b, required en=%b busy=%b sel=%0d pop=%h to=%b err=%b",
                         q[0].name, cyc, en, busy, sel, pop, tmo, err,
                         q[0].exp[23], q[0].exp[22], q[0].exp[21:18], q[0].exp[17:2],
                         q[0].exp[1], q[0].exp[0]);
            end
            void'(q.pop_front());
        end else if (rst_n === 1'b1 && (pop != 16'h0 || tmo || err)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output cyc=%0d: got pop=%h to=%b err=%b, required none",
                     cyc, pop, tmo, err);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        {rdy, vld, sop, eop} = 4'b0000;
        do_reset();

        tname = "single_packet";
        drive(16'h0004, 4'b0000, 0, 0, 16'h0000, 2'b00);
        drive(16'h0004, 4'b1110, 1, 2, 16'h0004, 2'b00);
        drive(16'h0004, 4'b1100, 1, 2, 16'h0004, 2'b00);
        drive(16'h0004, 4'b1100, 1, 2, 16'h0004, 2'b00);
        drive(16'h0004, 4'b1101, 1, 2, 16'h0004, 2'b00);
        drive(16'h0004, 4'b1100, 0, 2, 16'h0000, 2'b00);
        tname = "ptr_after_eop";
        drive(16'h0009, 4'b1100, 0, 2, 16'h0000, 2'b00);
        drive(16'h0009, 4'b1111, 1, 3, 16'h0008, 2'b00);
        drive(16'h0000, 4'b1100, 0, 3, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1100, 0, 3, 16'h0000, 2'b00);

        do_reset();
        tname = "round_robin";
        drive(16'h8011, 4'b1100, 0, 0,  16'h0000, 2'b00);
        drive(16'h8011, 4'b1110, 1, 0,  16'h0001, 2'b00);
        drive(16'h8011, 4'b1101, 1, 0,  16'h0001, 2'b00);
        drive(16'h8011, 4'b1100, 0, 0,  16'h0000, 2'b00);
        drive(16'h8011, 4'b1100, 0, 0,  16'h0000, 2'b00);
        drive(16'h8011, 4'b1110, 1, 4,  16'h0010, 2'b00);
        drive(16'h8011, 4'b1101, 1, 4,  16'h0010, 2'b00);
        drive(16'h8011, 4'b1100, 0, 4,  16'h0000, 2'b00);
        drive(16'h8011, 4'b1100, 0, 4,  16'h0000, 2'b00);
        drive(16'h8011, 4'b1110, 1, 15, 16'h8000, 2'b00);
        drive(16'h8011, 4'b1101, 1, 15, 16'h8000, 2'b00);
        drive(16'h8011, 4'b1100, 0, 15, 16'h0000, 2'b00);
        drive(16'h8011, 4'b1100, 0, 15, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1110, 1, 0,  16'h0001, 2'b00);
        drive(16'h0000, 4'b1101, 1, 0,  16'h0001, 2'b00);
        drive(16'h0000, 4'b1100, 0, 0,  16'h0000, 2'b00);
        drive(16'h0000, 4'b1100, 0, 0,  16'h0000, 2'b00);

        do_reset();
        tname = "backpressure";
        drive(16'h0002, 4'b0000, 0, 0, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1110, 1, 1, 16'h0002, 2'b00);
        drive(16'h0000, 4'b0100, 1, 1, 16'h0000, 2'b00);
        for (int i = 0; i < 4; i++) drive(16'h0000, 4'b0000, 1, 1, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1100, 1, 1, 16'h0002, 2'b00);
        drive(16'h0000, 4'b0101, 1, 1, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1101, 1, 1, 16'h0002, 2'b00);
        drive(16'h0000, 4'b1100, 0, 1, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1100, 0, 1, 16'h0000, 2'b00);

        do_reset();
        tname = "watchdog";
        drive(16'h0060, 4'b0000, 0, 0, 16'h0000, 2'b00);
        drive(16'h0060, 4'b1110, 1, 5, 16'h0020, 2'b00);
        drive(16'h0060, 4'b1000, 1, 5, 16'h0000, 2'b00);
        drive(16'h0060, 4'b0000, 1, 5, 16'h0000, 2'b00);
        drive(16'h0060, 4'b1000, 1, 5, 16'h0000, 2'b00);
        drive(16'h0060, 4'b1000, 1, 5, 16'h0000, 2'b00);
        drive(16'h0060, 4'b1000, 1, 5, 16'h0000, 2'b10);
        drive(16'h0060, 4'b1100, 0, 5, 16'h0000, 2'b00);
        drive(16'h0060, 4'b1100, 0, 5, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1111, 1, 6, 16'h0040, 2'b00);
        drive(16'h0000, 4'b1100, 0, 6, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1100, 0, 6, 16'h0000, 2'b00);

        do_reset();
        tname = "framing";
        drive(16'h0100, 4'b0000, 0, 0, 16'h0000, 2'b00);
        drive(16'h0100, 4'b1100, 1, 8, 16'h0100, 2'b01);
        drive(16'h0100, 4'b1000, 1, 8, 16'h0000, 2'b00);
        drive(16'h0100, 4'b1000, 1, 8, 16'h0000, 2'b00);
        drive(16'h0100, 4'b1110, 1, 8, 16'h0100, 2'b01);
        drive(16'h0100, 4'b1000, 1, 8, 16'h0000, 2'b00);
        drive(16'h0100, 4'b1000, 1, 8, 16'h0000, 2'b00);
        drive(16'h0100, 4'b1000, 1, 8, 16'h0000, 2'b00);
        drive(16'h0100, 4'b1101, 1, 8, 16'h0100, 2'b00);
        drive(16'h0000, 4'b1100, 0, 8, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1100, 0, 8, 16'h0000, 2'b00);

        tname = "reset_mid_packet";
        drive(16'h0200, 4'b0000, 0, 8, 16'h0000, 2'b00);
        drive(16'h0200, 4'b1110, 1, 9, 16'h0200, 2'b00);
        do_reset();
        drive(16'h0201, 4'b1100, 0, 0, 16'h0000, 2'b00);
        drive(16'h0200, 4'b1111, 1, 0, 16'h0001, 2'b00);
        drive(16'h0200, 4'b1100, 0, 0, 16'h0000, 2'b00);
        drive(16'h0200, 4'b1100, 0, 0, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1111, 1, 9, 16'h0200, 2'b00);
        drive(16'h0000, 4'b1100, 0, 9, 16'h0000, 2'b00);
        drive(16'h0000, 4'b1100, 0, 9, 16'h0000, 2'b00);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rd_port_sched.md
# rd_port_sched

Per-output-port read scheduler for the multi-port cache. It arbitrates among the `IN_PORT_NUM` input-port packet buffers that hold a complete packet for this output, using packet-granular round-robin. It drives the select/enable of the 16:1 read mux and pops the granted buffer word by word until end-of-packet. It also guards against stalled packets and malformed packet framing.

## Interface
Parameters:
- `IN_PORT_NUM`, 16: number of requesting input ports; must be a power of 2.
- `TIMEOUT`, 255: consecutive stalled cycles in a packet before the grant is revoked; range 1..65535.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset, synchronous, active-low.
- `i_req`, in, `[IN_PORT_NUM-1:0]`: bit k high means port k's buffer holds at least one complete packet for this output.
- `i_out_rdy`, in, 1: downstream accepts a word this cycle.
- `i_rd_vld`, in, 1: head-word valid of the selected buffer. This is the mux output, show-ahead (FWFT).
- `i_rd_sop`, in, 1: head word is start-of-packet (mux output).
- `i_rd_eop`, in, 1: head word is end-of-packet (mux output).
- `o_sel`, out, `$clog2(IN_PORT_NUM)`: mux select, registered.
- `o_en`, out, 1: mux enable, registered. High only in XFER.
- `o_pop`, out, `[IN_PORT_NUM-1:0]`: one-hot pop to buffer `o_sel`, combinational.
- `o_busy`, out, 1: high while in XFER.
- `o_timeout`, out, 1: one-cycle pulse when a grant is revoked by the watchdog.
- `o_err_sop`, out, 1: one-cycle pulse when the first word of a grant lacks sop, or a mid-packet word carries sop.

## Operation
- States: IDLE, XFER, GAP.
- **IDLE**
  - If `|i_req`, choose the first set bit at or after `ptr`, searching upward with wrap from `IN_PORT_NUM-1` to 0.
  - Register the winner into `o_sel`, set `o_en` to 1, clear the word flag and the stall counter, then go to XFER.
  - Otherwise stay in IDLE.
- **XFER**
  - Transfer condition: `xfer = o_en & i_out_rdy & i_rd_vld`.
  - `o_pop[o_sel] = xfer`; all other `o_pop` bits are 0.
  - First transferred word of the grant (`first` flag set): if `i_rd_sop=0`, pulse `o_err_sop`. On any later word, `i_rd_sop=1` also pulses `o_err_sop`. The word is forwarded regardless.
  - `xfer & i_rd_eop`:
    - `ptr <= o_sel+1`, modulo `IN_PORT_NUM`.
    - `o_en <= 0`.
    - Go to GAP.
  - Stall counter:
    - Increments on cycles with `o_en & i_out_rdy & !i_rd_vld`.
    - Holds on cycles with `!i_out_rdy`; downstream backpressure is never a timeout.
    - Clears on `xfer`.
  - Counter reaches `TIMEOUT`:
    - Pulse `o_timeout`.
    - `ptr <= o_sel+1`, `o_en <= 0`.
    - Go to GAP. No pop is issued that cycle.
- **GAP**
  - One bubble cycle so `i_req` reflects the consumed packet.
  - `o_en=0`, no pops. Always go to IDLE.
- Width rules:
  - `ptr` and `o_sel` wrap naturally at `IN_PORT_NUM`.
  - Stall counter width is `$clog2(TIMEOUT+1)` and it saturates at `TIMEOUT`.
- Boundary cases:
  - A single requester is re-granted after GAP.
  - `i_req` deasserting during XFER is ignored; the grant is held until eop or timeout.
  - A 1-word packet (sop&eop) completes in one XFER cycle.
  - `i_out_rdy=0` with eop present means no pop and no transition.

## Timing
- Reset (`i_rst_n=0` at a clock edge): state IDLE, `ptr=0`, `o_sel=0`, `o_en=0`, `o_busy=0`, `o_pop=0`, `o_timeout=0`, `o_err_sop=0`, stall counter 0, `first=1`.
- Reset mid-packet: the next cycle shows all outputs at reset values. The remainder of the packet stays in the buffer, and no partial pop follows.
- Arbitration latency: `i_req` seen in IDLE at cycle T gives `o_en=1` and `o_sel` valid at T+1. The earliest pop is at T+1.
- Packet turnaround: eop popped at T, GAP at T+1, IDLE arbitrates at T+2, next first pop at T+3.
  - Minimum overhead is 2 idle cycles per packet.
- Throughput inside a packet: 1 word per cycle while `i_out_rdy` and `i_rd_vld` are both high.
- `o_pop`, `o_err_sop` and `o_timeout` are combinational from state and inputs in the same cycle as the causing word or condition. `o_timeout` and `o_err_sop` are never asserted outside XFER.

## Test plan
- **Single packet.** `i_req=16'h0004`, 4-word packet, `i_out_rdy=1`.
  - Required: `o_sel=2`, `o_en` high for 4 cycles, `o_pop=16'h0004` for 4 cycles, then GAP.
  - Required: `ptr=3`.
- **Round-robin.** `i_req=16'h8011` held, 2-word packets.
  - Required: grant order 0,4,15,0.
  - Required: exactly 2 pops per grant, and 3 cycles from eop to the next pop.
- **Backpressure.** `i_out_rdy` toggles 1,0,0,1 during a 3-word packet.
  - Required: no pops on rdy=0 cycles, grant held, `o_timeout` never asserted even with `TIMEOUT=2`.
- **Watchdog.** `TIMEOUT=4`, port 5 granted, `i_rd_vld=0` after the first word.
  - Required: `o_timeout` pulse on the 4th stalled cycle, then GAP, then a grant to the next requester with `ptr=6`.
- **Framing errors.**
  - First word sop=0: `o_err_sop` pulses on that word and the packet still drains to eop.
  - Mid-packet sop=1: `o_err_sop` pulses on that word.
- **Reset mid-packet.** `i_rst_n=0` for 1 cycle during word 2 of 5 on port 9.
  - Required: next cycle `o_en=0`, `o_pop=0`, `ptr=0`.
  - Required: a subsequent `i_req=16'h0200` is re-granted with `o_sel=9`.
